// File: rtl/cpu_pkg.sv
// Shared definitions for the rv64i_mc_cpu multi-cycle core: opcode/funct fields,
// the end-of-program marker, FSM states and the decoded instruction class.
// Optional build macro CPU_ILLEGAL_FINISH_EN is consumed by rv64i_mc_cpu.sv.
package cpu_pkg;

   localparam int XLEN = 64;

   // Major opcodes
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   // funct3 values
   localparam logic [2:0] F3_DWORD = 3'b011;
   localparam logic [2:0] F3_ADD   = 3'b000;
   localparam logic [2:0] F3_SLL   = 3'b001;
   localparam logic [2:0] F3_XOR   = 3'b100;
   localparam logic [2:0] F3_SRL   = 3'b101;
   localparam logic [2:0] F3_OR    = 3'b110;
   localparam logic [2:0] F3_AND   = 3'b111;
   localparam logic [2:0] F3_BEQ   = 3'b000;
   localparam logic [2:0] F3_BNE   = 3'b001;

   // funct7 values
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_SUB  = 7'b0100000;

   // End-of-program marker
   localparam logic [31:0] EOF_INST = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      S_FETCH,
      S_IWAIT,
      S_EXEC,
      S_MREQ,
      S_MWAIT,
      S_WB,
      S_DONE
   } state_t;

   // Decoded instruction class; K_NOP also covers unsupported encodings
   typedef enum logic [2:0] {
      K_NOP,
      K_ALU,
      K_LOAD,
      K_STORE,
      K_BRANCH
   } kind_t;

   function automatic logic [XLEN-1:0] sext12(input logic [11:0] v);
      return {{(XLEN-12){v[11]}}, v};
   endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 32 x DATA_W integer register file, two combinational read ports, one write port.
// Latency: reads combinational, write lands on the rising edge.
// No backpressure; writes to x0 are dropped so x0 always reads zero.
module cpu_regfile
   import cpu_pkg::*;
#(
   parameter int DATA_W = XLEN
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_we,
   input  logic [4:0]        i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [4:0]        i_raddr1,
   input  logic [4:0]        i_raddr2,
   output logic [DATA_W-1:0] o_rdata1,
   output logic [DATA_W-1:0] o_rdata2
);

   logic [DATA_W-1:0] r_regs [0:31];

   // Register storage: cleared on reset, x0 never written
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < 32; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_we && (i_waddr != 5'd0)) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata1 = (i_raddr1 == 5'd0) ? '0 : r_regs[i_raddr1];
   assign o_rdata2 = (i_raddr2 == 5'd0) ? '0 : r_regs[i_raddr2];

endmodule

// File: rtl/rv64i_mc_cpu.sv
// Multi-cycle RV64I subset core (ld/sd/add/sub/xor/or/and/addi/xori/ori/andi/slli/srli/beq/bne).
// Latency: FETCH/IWAIT/EXEC/[MREQ/MWAIT]/WB per instruction; waits as long as memories take to respond.
// Macro CPU_ILLEGAL_FINISH_EN: unsupported encodings halt like EOF; otherwise they retire as NOPs.
module rv64i_mc_cpu
   import cpu_pkg::*;
#(
   parameter int INST_W = 32,
   parameter int DATA_W = 64,
   parameter int ADDR_W = 64
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_i_valid_inst,
   input  logic [INST_W-1:0] i_i_inst,
   input  logic              i_d_valid_data,
   input  logic [DATA_W-1:0] i_d_data,
   output logic              o_i_valid_addr,
   output logic [ADDR_W-1:0] o_i_addr,
   output logic [DATA_W-1:0] o_d_data,
   output logic [ADDR_W-1:0] o_d_addr,
   output logic              o_d_MemRead,
   output logic              o_d_MemWrite,
   output logic              o_finish
);

   // Architectural / FSM state
   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_pc;
   logic [INST_W-1:0] r_ir;

   // Values captured in EXEC for the later states
   kind_t             r_kind;
   logic [DATA_W-1:0] r_res;
   logic [ADDR_W-1:0] r_maddr;
   logic [DATA_W-1:0] r_sdata;
   logic              r_taken;
   logic [ADDR_W-1:0] r_target;

   // Instruction fields
   logic [6:0]        w_opcode;
   logic [4:0]        w_rd;
   logic [2:0]        w_f3;
   logic [4:0]        w_rs1;
   logic [4:0]        w_rs2;
   logic [6:0]        w_f7;
   logic [5:0]        w_shamt;
   logic              w_shift_ok;
   logic [XLEN-1:0]   w_imm_i;
   logic [XLEN-1:0]   w_imm_s;
   logic [XLEN-1:0]   w_imm_b;

   // Decode / execute results
   logic [DATA_W-1:0] w_rs1_val;
   logic [DATA_W-1:0] w_rs2_val;
   kind_t             w_kind;
   logic [DATA_W-1:0] w_alu;
   logic              w_taken;
   logic [ADDR_W-1:0] w_maddr;
   logic              w_halt;

   // Register file write port
   logic              w_rf_we;

   assign w_opcode   = r_ir[6:0];
   assign w_rd       = r_ir[11:7];
   assign w_f3       = r_ir[14:12];
   assign w_rs1      = r_ir[19:15];
   assign w_rs2      = r_ir[24:20];
   assign w_f7       = r_ir[31:25];
   assign w_shamt    = r_ir[25:20];
   assign w_shift_ok = (r_ir[31:26] == 6'b000000);

   assign w_imm_i = sext12(r_ir[31:20]);
   assign w_imm_s = sext12({r_ir[31:25], r_ir[11:7]});
   assign w_imm_b = {{(XLEN-13){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};

   cpu_regfile #(
      .DATA_W (DATA_W)
   ) u_regfile (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_we     (w_rf_we),
      .i_waddr  (w_rd),
      .i_wdata  (r_res),
      .i_raddr1 (w_rs1),
      .i_raddr2 (w_rs2),
      .o_rdata1 (w_rs1_val),
      .o_rdata2 (w_rs2_val)
   );

   // Decode and ALU: classify IR and compute result / branch decision
   always_comb begin
      w_kind  = K_NOP;
      w_alu   = '0;
      w_taken = 1'b0;
      case (w_opcode)
         OPC_LOAD: begin
            if (w_f3 == F3_DWORD) w_kind = K_LOAD;
         end
         OPC_STORE: begin
            if (w_f3 == F3_DWORD) w_kind = K_STORE;
         end
         OPC_OP: begin
            case (w_f3)
               F3_ADD: begin
                  if (w_f7 == F7_BASE) begin
                     w_kind = K_ALU;
                     w_alu  = w_rs1_val + w_rs2_val;
                  end else if (w_f7 == F7_SUB) begin
                     w_kind = K_ALU;
                     w_alu  = w_rs1_val - w_rs2_val;
                  end
               end
               F3_XOR: begin
                  if (w_f7 == F7_BASE) begin
                     w_kind = K_ALU;
                     w_alu  = w_rs1_val ^ w_rs2_val;
                  end
               end
               F3_OR: begin
                  if (w_f7 == F7_BASE) begin
                     w_kind = K_ALU;
                     w_alu  = w_rs1_val | w_rs2_val;
                  end
               end
               F3_AND: begin
                  if (w_f7 == F7_BASE) begin
                     w_kind = K_ALU;
                     w_alu  = w_rs1_val & w_rs2_val;
                  end
               end
               default: ;
            endcase
         end
         OPC_OPIMM: begin
            case (w_f3)
               F3_ADD: begin
                  w_kind = K_ALU;
                  w_alu  = w_rs1_val + DATA_W'(w_imm_i);
               end
               F3_XOR: begin
                  w_kind = K_ALU;
                  w_alu  = w_rs1_val ^ DATA_W'(w_imm_i);
               end
               F3_OR: begin
                  w_kind = K_ALU;
                  w_alu  = w_rs1_val | DATA_W'(w_imm_i);
               end
               F3_AND: begin
                  w_kind = K_ALU;
                  w_alu  = w_rs1_val & DATA_W'(w_imm_i);
               end
               F3_SLL: begin
                  if (w_shift_ok) begin
                     w_kind = K_ALU;
                     w_alu  = w_rs1_val << w_shamt;
                  end
               end
               F3_SRL: begin
                  if (w_shift_ok) begin
                     w_kind = K_ALU;
                     w_alu  = w_rs1_val >> w_shamt;
                  end
               end
               default: ;
            endcase
         end
         OPC_BRANCH: begin
            if (w_f3 == F3_BEQ) begin
               w_kind  = K_BRANCH;
               w_taken = (w_rs1_val == w_rs2_val);
            end else if (w_f3 == F3_BNE) begin
               w_kind  = K_BRANCH;
               w_taken = (w_rs1_val != w_rs2_val);
            end
         end
         default: ;
      endcase
   end

   // Loads use the I-immediate, stores the S-immediate
   assign w_maddr = ADDR_W'(w_rs1_val + ((w_kind == K_STORE) ? DATA_W'(w_imm_s) : DATA_W'(w_imm_i)));

`ifdef CPU_ILLEGAL_FINISH_EN
   assign w_halt = (r_ir == EOF_INST) || (w_kind == K_NOP);
`else
   assign w_halt = (r_ir == EOF_INST);
`endif

   // FSM state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_FETCH;
      else          r_state <= w_next;
   end

   // FSM next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH: w_next = S_IWAIT;
         S_IWAIT: if (i_i_valid_inst) w_next = S_EXEC;
         S_EXEC: begin
            if (w_halt)                                         w_next = S_DONE;
            else if ((w_kind == K_LOAD) || (w_kind == K_STORE)) w_next = S_MREQ;
            else                                                w_next = S_WB;
         end
         S_MREQ:  w_next = (r_kind == K_LOAD) ? S_MWAIT : S_WB;
         S_MWAIT: if (i_d_valid_data) w_next = S_WB;
         S_WB:    w_next = S_FETCH;
         S_DONE:  w_next = S_DONE;
         default: w_next = S_FETCH;
      endcase
   end

   // FSM outputs: strobes are decoded from state and held low while reset is asserted
   always_comb begin
      o_i_valid_addr = i_rst_n && (r_state == S_FETCH);
      o_d_MemRead    = i_rst_n && (r_state == S_MREQ) && (r_kind == K_LOAD);
      o_d_MemWrite   = i_rst_n && (r_state == S_MREQ) && (r_kind == K_STORE);
      o_finish       = i_rst_n && (r_state == S_DONE);
      o_i_addr       = r_pc;
      o_d_addr       = r_maddr;
      o_d_data       = r_sdata;
   end

   // Datapath registers: IR capture, EXEC results, load data, PC update
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pc     <= '0;
         r_ir     <= '0;
         r_kind   <= K_NOP;
         r_res    <= '0;
         r_maddr  <= '0;
         r_sdata  <= '0;
         r_taken  <= 1'b0;
         r_target <= '0;
      end else begin
         case (r_state)
            S_IWAIT: begin
               if (i_i_valid_inst) r_ir <= i_i_inst;
            end
            S_EXEC: begin
               r_kind   <= w_kind;
               r_res    <= w_alu;
               r_maddr  <= w_maddr;
               r_sdata  <= w_rs2_val;
               r_taken  <= w_taken;
               r_target <= r_pc + ADDR_W'(w_imm_b);
            end
            S_MWAIT: begin
               if (i_d_valid_data) r_res <= i_d_data;
            end
            S_WB: begin
               r_pc <= r_taken ? r_target : (r_pc + ADDR_W'(4));
            end
            default: ;
         endcase
      end
   end

   // Only ALU ops and loads retire a register value
   assign w_rf_we = (r_state == S_WB) && ((r_kind == K_ALU) || (r_kind == K_LOAD));

endmodule

// File: tb/tb_rv64i_mc_cpu.sv
// Directed self-checking bench for rv64i_mc_cpu with behavioural instruction/data memories.
// Memory response latency is adjustable; stores land in a byte-array little-endian memory.
// Default build expects unsupported encodings to retire as NOPs.
module tb_rv64i_mc_cpu;

   localparam logic [6:0] OPI = 7'b0010011;
   localparam logic [6:0] OPR = 7'b0110011;
   localparam logic [6:0] OLD = 7'b0000011;
   localparam logic [6:0] OST = 7'b0100011;
   localparam logic [6:0] OBR = 7'b1100011;
   localparam logic [31:0] EOF_W = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_i_valid_inst;
   logic [31:0] i_i_inst;
   logic        i_d_valid_data;
   logic [63:0] i_d_data;
   logic        o_i_valid_addr;
   logic [63:0] o_i_addr;
   logic [63:0] o_d_data;
   logic [63:0] o_d_addr;
   logic        o_d_MemRead;
   logic        o_d_MemWrite;
   logic        o_finish;

   logic [31:0] imem [0:63];
   logic [7:0]  dmem [0:255];
   int          vectors = 0;
   int          miscompares = 0;
   int          lat_i = 1;
   int          lat_d = 1;
   int          n_fetch = 0;
   logic [63:0] first_fetch = '0;
   int          wp = 0;

   always #5 clk = ~clk;

   rv64i_mc_cpu dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_i_valid_inst (i_i_valid_inst),
      .i_i_inst       (i_i_inst),
      .i_d_valid_data (i_d_valid_data),
      .i_d_data       (i_d_data),
      .o_i_valid_addr (o_i_valid_addr),
      .o_i_addr       (o_i_addr),
      .o_d_data       (o_d_data),
      .o_d_addr       (o_d_addr),
      .o_d_MemRead    (o_d_MemRead),
      .o_d_MemWrite   (o_d_MemWrite),
      .o_finish       (o_finish)
   );

   function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                         logic [4:0] rd, logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                         logic [2:0] f3, logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, OPR};
   endfunction

   function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], OST};
   endfunction

   function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                         logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OBR};
   endfunction

   function automatic logic [63:0] rd64(int a);
      logic [63:0] v;
      for (int b = 0; b < 8; b++) v[8*b +: 8] = dmem[(a + b) % 256];
      return v;
   endfunction

   // Memory responders: sample requests mid-cycle, answer after lat cycles
   initial begin
      int          i_cnt;
      int          d_cnt;
      logic [63:0] i_pa;
      logic [63:0] d_pa;
      i_cnt = -1; d_cnt = -1; i_pa = '0; d_pa = '0;
      i_i_valid_inst = 1'b0; i_i_inst = '0; i_d_valid_data = 1'b0; i_d_data = '0;
      forever begin
         @(negedge clk);
         #1;
         i_i_valid_inst = 1'b0;
         i_d_valid_data = 1'b0;
         if (!rst_n) begin
            i_cnt = -1;
            d_cnt = -1;
         end else begin
            if (i_cnt > 0) begin
               i_cnt--;
               if (i_cnt == 0) begin
                  i_i_valid_inst = 1'b1;
                  i_i_inst = imem[i_pa[7:2]];
                  i_cnt = -1;
               end
            end
            if (d_cnt > 0) begin
               d_cnt--;
               if (d_cnt == 0) begin
                  i_d_valid_data = 1'b1;
                  i_d_data = rd64(int'(d_pa[7:0]));
                  d_cnt = -1;
               end
            end
            if (o_i_valid_addr) begin
               if (n_fetch == 0) first_fetch = o_i_addr;
               n_fetch++;
               i_pa = o_i_addr;
               i_cnt = lat_i;
            end
            if (o_d_MemRead) begin
               d_pa = o_d_addr;
               d_cnt = lat_d;
            end
            if (o_d_MemWrite) begin
               for (int b = 0; b < 8; b++) dmem[(int'(o_d_addr[7:0]) + b) % 256] = o_d_data[8*b +: 8];
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_mem(input logic [7:0] fill);
      for (int k = 0; k < 64; k++) imem[k] = EOF_W;
      for (int k = 0; k < 256; k++) dmem[k] = fill;
      wp = 0;
   endtask

   task automatic put(input logic [31:0] ins);
      imem[wp] = ins;
      wp++;
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      chk({tag, "_rst_strobes"}, {60'd0, o_i_valid_addr, o_d_MemRead, o_d_MemWrite, o_finish}, 64'd0);
      chk({tag, "_rst_iaddr"}, o_i_addr, 64'd0);
      chk({tag, "_rst_daddr_ddata"}, o_d_addr | o_d_data, 64'd0);
      @(negedge clk);
      n_fetch = 0;
      rst_n = 1'b1;
   endtask

   task automatic run(input string tag);
      int n;
      n = 0;
      while (o_finish !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_finish"}, {63'd0, o_finish}, 64'd1);
   endtask

   task automatic prog_ld_sd();
      clear_mem(8'h00);
      dmem[0] = 8'h88; dmem[1] = 8'h77; dmem[2] = 8'h66; dmem[3] = 8'h55;
      dmem[4] = 8'h44; dmem[5] = 8'h33; dmem[6] = 8'h22; dmem[7] = 8'h11;
      put(enc_i(12'd0, 5'd0, 3'b011, 5'd2, OLD));   // ld x2,0(x0)
      put(enc_s(12'd16, 5'd2, 5'd0));               // sd x2,16(x0)
      put(EOF_W);
   endtask

   initial begin
      int n;
      logic [7:0] acc;

      // 1: EOF only
      clear_mem(8'h00);
      do_reset("t1");
      run("t1");
      chk("t1_fetches", 64'(n_fetch), 64'd1);
      chk("t1_first_pc", first_fetch, 64'd0);
      acc = 8'h00;
      for (int k = 0; k < 256; k++) acc = acc | dmem[k];
      chk("t1_dmem_zero", {56'd0, acc}, 64'd0);
      repeat (20) @(negedge clk);
      chk("t1_finish_held", {63'd0, o_finish}, 64'd1);
      chk("t1_no_more_fetch", 64'(n_fetch), 64'd1);

      // 2: addi + sd
      clear_mem(8'h00);
      put(enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPI));   // addi x1,x0,5
      put(enc_s(12'd8, 5'd1, 5'd0));                // sd x1,8(x0)
      put(EOF_W);
      do_reset("t2");
      run("t2");
      chk("t2_mem8", rd64(8), 64'd5);
      chk("t2_byte8", {56'd0, dmem[8]}, 64'h05);

      // 3: ld then sd, little-endian byte order
      prog_ld_sd();
      do_reset("t3");
      run("t3");
      chk("t3_dword16", rd64(16), 64'h1122334455667788);
      chk("t3_byte16", {56'd0, dmem[16]}, 64'h88);
      chk("t3_byte23", {56'd0, dmem[23]}, 64'h11);

      // 4: ALU ops; memory prefilled so each sd must write all 8 bytes
      clear_mem(8'hAA);
      put(enc_i(12'd7, 5'd0, 3'b000, 5'd1, OPI));            // addi x1,x0,7
      put(enc_i(12'd9, 5'd0, 3'b000, 5'd2, OPI));            // addi x2,x0,9
      put(enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3));      // sub x3,x1,x2
      put(enc_s(12'd0, 5'd3, 5'd0));
      put(enc_r(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd4));      // and
      put(enc_s(12'd8, 5'd4, 5'd0));
      put(enc_r(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd5));      // or
      put(enc_s(12'd16, 5'd5, 5'd0));
      put(enc_r(7'b0000000, 5'd2, 5'd1, 3'b100, 5'd6));      // xor
      put(enc_s(12'd24, 5'd6, 5'd0));
      put(enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd7));      // add
      put(enc_s(12'd32, 5'd7, 5'd0));
      put(enc_i({6'd0, 6'd60}, 5'd1, 3'b001, 5'd8, OPI));    // slli x8,x1,60
      put(enc_i({6'd0, 6'd63}, 5'd8, 3'b101, 5'd8, OPI));    // srli x8,x8,63
      put(enc_s(12'd40, 5'd8, 5'd0));
      put(enc_i({6'd0, 6'd61}, 5'd1, 3'b001, 5'd9, OPI));    // slli x9,x1,61
      put(enc_i({6'd0, 6'd63}, 5'd9, 3'b101, 5'd9, OPI));    // srli x9,x9,63
      put(enc_s(12'd48, 5'd9, 5'd0));
      put(enc_i({6'd0, 6'd4}, 5'd1, 3'b001, 5'd10, OPI));    // slli x10,x1,4
      put(enc_s(12'd56, 5'd10, 5'd0));
      put(enc_i(12'hFFF, 5'd0, 3'b000, 5'd11, OPI));         // addi x11,x0,-1
      put(enc_i({6'd0, 6'd4}, 5'd11, 3'b101, 5'd12, OPI));   // srli x12,x11,4
      put(enc_s(12'd64, 5'd12, 5'd0));
      put(enc_i(12'hFFF, 5'd1, 3'b100, 5'd13, OPI));         // xori x13,x1,-1
      put(enc_s(12'd72, 5'd13, 5'd0));
      put(enc_i(12'd8, 5'd1, 3'b110, 5'd14, OPI));           // ori x14,x1,8
      put(enc_s(12'd80, 5'd14, 5'd0));
      put(enc_i(12'd3, 5'd2, 3'b111, 5'd15, OPI));           // andi x15,x2,3
      put(enc_s(12'd88, 5'd15, 5'd0));
      put(enc_i(12'd5, 5'd0, 3'b000, 5'd0, OPI));            // addi x0,x0,5
      put(enc_s(12'd96, 5'd0, 5'd0));
      put(enc_i(12'hFF6, 5'd2, 3'b000, 5'd16, OPI));         // addi x16,x2,-10
      put(enc_s(12'd104, 5'd16, 5'd0));
      put(EOF_W);
      do_reset("t4");
      run("t4");
      chk("t4_sub", rd64(0), 64'hFFFF_FFFF_FFFF_FFFE);
      chk("t4_and", rd64(8), 64'd1);
      chk("t4_or", rd64(16), 64'd15);
      chk("t4_xor", rd64(24), 64'd14);
      chk("t4_add", rd64(32), 64'd16);
      chk("t4_sll60_srl63", rd64(40), 64'd0);
      chk("t4_sll61_srl63", rd64(48), 64'd1);
      chk("t4_slli4", rd64(56), 64'h70);
      chk("t4_srli_logical", rd64(64), 64'h0FFF_FFFF_FFFF_FFFF);
      chk("t4_xori_neg", rd64(72), 64'hFFFF_FFFF_FFFF_FFF8);
      chk("t4_ori", rd64(80), 64'd15);
      chk("t4_andi", rd64(88), 64'd1);
      chk("t4_x0_zero", rd64(96), 64'd0);
      chk("t4_addi_wrap", rd64(104), 64'hFFFF_FFFF_FFFF_FFFF);

      // 5: branches and an unsupported encoding
      clear_mem(8'h00);
      put(enc_i(12'h055, 5'd0, 3'b000, 5'd1, OPI));          // 0  addi x1,x0,0x55
      put(enc_b(13'd8, 5'd0, 5'd0, 3'b000));                 // 4  beq x0,x0,+8
      put(enc_s(12'd0, 5'd1, 5'd0));                         // 8  skipped
      put(enc_b(13'd8, 5'd0, 5'd0, 3'b001));                 // 12 bne x0,x0,+8
      put(enc_s(12'd8, 5'd1, 5'd0));                         // 16 executes
      put(enc_i(12'd1, 5'd0, 3'b000, 5'd2, OPI));            // 20 addi x2,x0,1
      put(enc_b(13'd8, 5'd0, 5'd2, 3'b001));                 // 24 bne x2,x0,+8
      put(enc_s(12'd16, 5'd1, 5'd0));                        // 28 skipped
      put(enc_b(13'd8, 5'd0, 5'd2, 3'b000));                 // 32 beq x2,x0,+8
      put(enc_s(12'd24, 5'd1, 5'd0));                        // 36 executes
      put(enc_r(7'b0000001, 5'd1, 5'd1, 3'b000, 5'd3));      // 40 unsupported
      put(enc_s(12'd32, 5'd3, 5'd0));                        // 44 sd x3
      put(enc_s(12'd40, 5'd1, 5'd0));                        // 48 sd x1
      put(EOF_W);                                            // 52
      do_reset("t5");
      run("t5");
      chk("t5_beq_skip", rd64(0), 64'd0);
      chk("t5_bne_fallthru", rd64(8), 64'h55);
      chk("t5_bne_skip", rd64(16), 64'd0);
      chk("t5_beq_fallthru", rd64(24), 64'h55);
      chk("t5_illegal_no_wr", rd64(32), 64'd0);
`ifdef CPU_ILLEGAL_FINISH_EN
      chk("t5_after_illegal", rd64(40), 64'd0);
      chk("t5_fetches", 64'(n_fetch), 64'd9);
`else
      chk("t5_after_illegal", rd64(40), 64'h55);
      chk("t5_fetches", 64'(n_fetch), 64'd12);
`endif

      // 6: slow memories, then reset in the middle of an instruction wait
      lat_i = 5;
      lat_d = 5;
      prog_ld_sd();
      do_reset("t6a");
      run("t6a");
      chk("t6a_dword16", rd64(16), 64'h1122334455667788);
      chk("t6a_fetches", 64'(n_fetch), 64'd3);

      prog_ld_sd();
      do_reset("t6b");
      n = 0;
      while (n_fetch < 2 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("t6b_reached_fetch2", {63'd0, n_fetch >= 2}, 64'd1);
      repeat (2) @(negedge clk);
      chk("t6b_no_finish_yet", {63'd0, o_finish}, 64'd0);
      do_reset("t6c");
      run("t6c");
      chk("t6c_restart_pc", first_fetch, 64'd0);
      chk("t6c_dword16", rd64(16), 64'h1122334455667788);
      chk("t6c_src_intact", rd64(0), 64'h1122334455667788);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
